dino_jump_engine: RTL and testbench
===================================

DINO_JUMP_ENGINE -- requirements
Module: dino_jump_engine

Interface
REQ-001 Parameter GROUND_Y, default 400: screen row of the ground line (the dino's feet when landed).
REQ-002 Parameter DINO_X, default 40; DINO_W, default 20: leftmost sprite column and sprite width.
REQ-003 Parameters DINO_H, default 24; DUCK_H, default 12: standing and ducking sprite heights.
REQ-004 Parameters V0, default 12; G, default 1: launch velocity and gravity decrement per frame, both in pixels/frame.
REQ-005 Parameter MAX_JUMPS, default 2, range 1..3: jumps allowed before landing (2 means double jump).
REQ-006 Parameter H_MAX, default 255: height saturation limit; H_W, default 9: width of the height register.
REQ-007 CLK  in  1  the single clock; all logic is rising-edge.
REQ-008 RESET  in  1  synchronous, active-high reset.
REQ-009 fresh  in  1  one-cycle frame-tick pulse; all physics updates happen only on this tick.
REQ-010 button_jump  in  1  jump button, level, synchronous to CLK.
REQ-011 button_duck  in  1  duck button, level.
REQ-012 freeze  in  1  game-over hold; while high, all state is held.
REQ-013 row_addr  in  9  current VGA row; col_addr  in  10  current VGA column.
REQ-014 px  out  1  sprite pixel-on flag, registered.
REQ-015 height  out  H_W  current height above ground; airborne  out  1  high when not in the GROUND state.

Function
REQ-016 Jump edge detection: a 0->1 transition of button_jump, sampled each CLK, sets jump_pending; jump_pending clears on the next fresh whether or not the jump is granted.
REQ-017 States are GROUND, RISE and FALL; state, height h, signed velocity v and jumps_used change only on cycles where fresh=1 and freeze=0.
REQ-018 From GROUND with jump_pending: h<=V0, v<=V0-G, jumps_used<=1, next state RISE.
REQ-019 Airborne with jump_pending and jumps_used<MAX_JUMPS: h<=h+V0, v<=V0-G, jumps_used increments; otherwise the request is dropped.
REQ-020 Airborne, no grant: if h+v<=0, land (h<=0, v<=0, jumps_used<=0, state GROUND); else h<=min(h+v,H_MAX) and v<=v-G.
REQ-021 After each airborne update, state is RISE if the new v>0 and FALL otherwise.
REQ-022 v is signed, wide enough for V0 plus the maximum fall speed; the sum h+v is computed at H_W+2 bits signed, with no wrap.
REQ-023 Ducking applies only when state=GROUND and button_duck=1: the sprite height becomes DUCK_H. If jump and duck arrive on the same tick, the jump wins and ducking ends.
REQ-024 px is asserted one cycle after the address when DINO_X<=col_addr<DINO_X+DINO_W and GROUND_Y-h-Hcur<=row_addr<GROUND_Y-h, where Hcur is DINO_H or DUCK_H.
REQ-025 Pixel comparisons are done unsigned at 11 bits. A sprite top that would fall below row 0 is clamped to row 0.
REQ-026 freeze=1 holds h, v, state and jumps_used, and clears jump_pending. px keeps rendering the frozen position.
REQ-027 fresh and a button edge on the same cycle: the edge is registered and takes effect on the next fresh.

Reset
REQ-028 On RESET=1 at a CLK edge: state=GROUND, h=0, v=0, jumps_used=0, jump_pending=0, px=0, airborne=0.
REQ-029 RESET takes priority over fresh and freeze, and reset mid-jump returns the dino to the ground immediately.

Verification
REQ-030 Defaults; pulse the jump button, then 25 fresh ticks -> h is 12,23,33,...,78 at tick 12, back to 0 at tick 25; airborne=0 after tick 25.
REQ-031 Press at tick 12 (h=78), then press again -> next tick h=90, v=11; a third press is ignored (MAX_JUMPS=2).
REQ-032 Hold duck on ground; row=399, col=40 -> px=1; row=388 -> px=1; row=387 -> px=0; releasing duck makes row=376 give px=1.
REQ-033 freeze=1 at h=33 for 10 ticks -> h stays 33; press jump during freeze -> no jump after freeze drops.
REQ-034 RESET at h=50 mid-rise -> next cycle h=0, state GROUND, px=0; a later press jumps normally.
REQ-035 V0=30, H_MAX=255, G=1 -> h saturates at 255 without wrap, then descends and lands at h=0.

Source files
------------

// File: rtl/dino_jump_engine.sv
// Dino runner jump physics: frame-ticked height/velocity integrator with multi-jump,
// ducking, freeze hold and a registered sprite pixel flag for the VGA scan.
module dino_jump_engine #(
    parameter int GROUND_Y  = 400,
    parameter int DINO_X    = 40,
    parameter int DINO_W    = 20,
    parameter int DINO_H    = 24,
    parameter int DUCK_H    = 12,
    parameter int V0        = 12,
    parameter int G         = 1,
    parameter int MAX_JUMPS = 2,
    parameter int H_MAX     = 255,
    parameter int H_W       = 9
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           fresh,
    input  logic           button_jump,
    input  logic           button_duck,
    input  logic           freeze,
    input  logic [8:0]     row_addr,
    input  logic [9:0]     col_addr,
    output logic           px,
    output logic [H_W-1:0] height,
    output logic           airborne
);

    localparam int SW = H_W + 2;
    localparam logic signed [SW-1:0] V0_S    = SW'(V0);
    localparam logic signed [SW-1:0] G_S     = SW'(G);
    localparam logic signed [SW-1:0] H_MAX_S = SW'(H_MAX);
    localparam logic [H_W-1:0]       H_MAX_U = H_W'(H_MAX);
    localparam logic [1:0]           MAX_J   = 2'(MAX_JUMPS);
    localparam logic [10:0]          GY      = 11'(GROUND_Y);
    localparam logic [10:0]          X_LO    = 11'(DINO_X);
    localparam logic [10:0]          X_HI    = 11'(DINO_X + DINO_W);
    localparam logic [10:0]          H_STAND = 11'(DINO_H);
    localparam logic [10:0]          H_DUCK  = 11'(DUCK_H);

    typedef enum logic [1:0] {StGround, StRise, StFall} state_e;

    state_e                state_q, state_d;
    logic [H_W-1:0]        h_q, h_d;
    logic signed [SW-1:0]  v_q, v_d;
    logic [1:0]            jumps_q, jumps_d;
    logic                  jump_prev_q;
    logic                  pending_q, pending_d;
    logic                  px_q, px_d;

    logic                  jump_edge;
    logic                  grant;
    logic signed [SW-1:0]  h_ext;
    logic signed [SW-1:0]  sum_air;
    logic signed [SW-1:0]  v_air;
    logic [10:0]           hcur, bot, top, row11, col11;

    function automatic logic [H_W-1:0] sat_h(input logic signed [SW-1:0] x);
        if (x > H_MAX_S) return H_MAX_U;
        return x[H_W-1:0];
    endfunction

    assign jump_edge = button_jump & ~jump_prev_q;
    assign h_ext     = signed'({2'b00, h_q});
    assign grant     = pending_q && (jumps_q < MAX_J);
    assign sum_air   = grant ? (h_ext + V0_S) : (h_ext + v_q);
    assign v_air     = grant ? (V0_S - G_S) : (v_q - G_S);

    // A fresh tick consumes the pending request; an edge on the same cycle survives it.
    always_comb begin
        pending_d = pending_q;
        if (freeze)         pending_d = 1'b0;
        else if (fresh)     pending_d = jump_edge;
        else if (jump_edge) pending_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        jumps_d = jumps_q;
        if (fresh && !freeze) begin
            case (state_q)
                StGround: begin
                    if (pending_q) begin
                        h_d     = sat_h(V0_S);
                        v_d     = V0_S - G_S;
                        jumps_d = 2'd1;
                        state_d = StRise;
                    end
                end
                default: begin
                    if (!grant && sum_air <= 0) begin
                        h_d     = '0;
                        v_d     = '0;
                        jumps_d = '0;
                        state_d = StGround;
                    end else begin
                        h_d     = sat_h(sum_air);
                        v_d     = v_air;
                        jumps_d = grant ? jumps_q + 2'd1 : jumps_q;
                        state_d = (v_air > 0) ? StRise : StFall;
                    end
                end
            endcase
        end
    end

    // Sprite spans [bot-hcur, bot); the top clamps at row 0 when the dino is near the screen top.
    always_comb begin
        row11 = 11'(row_addr);
        col11 = 11'(col_addr);
        hcur  = (state_q == StGround && button_duck) ? H_DUCK : H_STAND;
        bot   = (11'(h_q) >= GY) ? 11'd0 : GY - 11'(h_q);
        top   = (bot > hcur) ? bot - hcur : 11'd0;
        px_d  = (col11 >= X_LO) && (col11 < X_HI) && (row11 >= top) && (row11 < bot);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StGround;
            h_q         <= '0;
            v_q         <= '0;
            jumps_q     <= '0;
            jump_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            px_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            jumps_q     <= jumps_d;
            jump_prev_q <= button_jump;
            pending_q   <= pending_d;
            px_q        <= px_d;
        end
    end

    assign px       = px_q;
    assign height   = h_q;
    assign airborne = (state_q != StGround);

endmodule

// File: tb/tb_dino_jump_engine.sv
// Scoreboard bench: directed scenarios queue hand-computed expectations, and a monitor
// compares them against the DUT outputs on the falling edge after each sample request.
module tb_dino_jump_engine;

    logic       CLK = 1'b0;
    logic       RESET, rst_sat;
    logic       fresh, button_jump, button_duck, freeze;
    logic [8:0] row_addr;
    logic [9:0] col_addr;
    logic       px, airborne, px_s, airborne_s;
    logic [8:0] height, height_s;
    logic       sample;

    int total = 0;
    int bad   = 0;

    typedef enum int {FH, FA, FP, SH, SA} field_e;
    typedef struct {
        field_e field;
        int     exp;
        string  name;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    dino_jump_engine u_dut (
        .CLK(CLK), .RESET(RESET), .fresh(fresh), .button_jump(button_jump),
        .button_duck(button_duck), .freeze(freeze), .row_addr(row_addr), .col_addr(col_addr),
        .px(px), .height(height), .airborne(airborne)
    );

    dino_jump_engine #(.V0(30), .G(1), .H_MAX(255)) u_sat (
        .CLK(CLK), .RESET(rst_sat), .fresh(fresh), .button_jump(button_jump),
        .button_duck(button_duck), .freeze(freeze), .row_addr(row_addr), .col_addr(col_addr),
        .px(px_s), .height(height_s), .airborne(airborne_s)
    );

    always @(negedge CLK) begin
        if (sample) begin
            while (sb.size() > 0) begin
                exp_t e;
                int   act;
                e = sb.pop_front();
                case (e.field)
                    FH:      act = int'(height);
                    FA:      act = int'(airborne);
                    FP:      act = int'(px);
                    SH:      act = int'(height_s);
                    default: act = int'(airborne_s);
                endcase
                total++;
                if (act != e.exp) begin
                    bad++;
                    $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        fresh = 1'b1;
        cyc();
        fresh = 1'b0;
    endtask

    task automatic press();
        button_jump = 1'b1;
        cyc();
        button_jump = 1'b0;
        cyc();
    endtask

    task automatic expect_v(input field_e f, input int e, input string n);
        exp_t x;
        x.field = f;
        x.exp   = e;
        x.name  = n;
        sb.push_back(x);
    endtask

    task automatic flush();
        sample = 1'b1;
        @(negedge CLK);
        #1 sample = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
    endtask

    task automatic pix(input int r, input int c, input int e, input string n);
        row_addr = 9'(r);
        col_addr = 10'(c);
        cyc();
        expect_v(FP, e, n);
        flush();
    endtask

    int traj[25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                     77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

    initial begin
        RESET = 1'b1; rst_sat = 1'b1; sample = 1'b0;
        fresh = 1'b0; button_jump = 1'b0; button_duck = 1'b0; freeze = 1'b0;
        row_addr = '0; col_addr = '0;
        repeat (3) cyc();
        RESET = 1'b0;

        expect_v(FH, 0, "reset_h");
        expect_v(FA, 0, "reset_air");
        expect_v(FP, 0, "reset_px");
        flush();

        // Edge on the same cycle as fresh only lands on the following tick.
        button_jump = 1'b1;
        fresh = 1'b1;
        cyc();
        fresh = 1'b0;
        button_jump = 1'b0;
        expect_v(FH, 0, "edge_with_fresh_h");
        expect_v(FA, 0, "edge_with_fresh_air");
        flush();
        for (int k = 1; k <= 25; k++) begin
            tick();
            expect_v(FH, traj[k-1], $sformatf("traj_h_t%0d", k));
            if (k == 1 || k == 24 || k == 25)
                expect_v(FA, (k == 25) ? 0 : 1, $sformatf("traj_air_t%0d", k));
            flush();
        end

        // Double jump at the apex, third press ignored.
        do_reset();
        press();
        repeat (12) tick();
        expect_v(FH, 78, "dj_apex");
        flush();
        press();
        tick();
        expect_v(FH, 90, "dj_second");
        flush();
        press();
        tick();
        expect_v(FH, 101, "dj_third_ignored");
        flush();
        tick();
        expect_v(FH, 111, "dj_v_decay");
        flush();

        // Ducking sprite on ground.
        do_reset();
        button_duck = 1'b1;
        pix(399, 40, 1, "duck_bottom");
        pix(388, 40, 1, "duck_top");
        pix(387, 40, 0, "duck_above");
        pix(399, 59, 1, "duck_right_col");
        pix(399, 60, 0, "duck_past_col");
        pix(399, 39, 0, "duck_before_col");
        button_duck = 1'b0;
        pix(376, 40, 1, "stand_top");
        pix(375, 40, 0, "stand_above");
        pix(400, 40, 0, "stand_below_ground");
        // Jump while duck held: the standing sprite is drawn in the air.
        button_duck = 1'b1;
        press();
        tick();
        expect_v(FH, 12, "jump_duck_h");
        flush();
        pix(370, 45, 1, "jump_duck_px");
        button_duck = 1'b0;

        // Freeze holds state and swallows a press.
        do_reset();
        press();
        repeat (3) tick();
        expect_v(FH, 33, "pre_freeze_h");
        flush();
        freeze = 1'b1;
        repeat (5) tick();
        press();
        repeat (5) tick();
        expect_v(FH, 33, "freeze_hold_h");
        expect_v(FA, 1, "freeze_hold_air");
        flush();
        pix(350, 50, 1, "freeze_px");
        freeze = 1'b0;
        tick();
        expect_v(FH, 42, "post_freeze_no_jump");
        flush();

        // Reset mid-rise.
        do_reset();
        press();
        repeat (5) tick();
        expect_v(FH, 50, "pre_reset_h");
        flush();
        pix(340, 45, 1, "pre_reset_px");
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        expect_v(FH, 0, "post_reset_h");
        expect_v(FA, 0, "post_reset_air");
        expect_v(FP, 0, "post_reset_px");
        flush();
        press();
        tick();
        expect_v(FH, 12, "post_reset_jump");
        flush();

        // Saturating instance (V0=30).
        rst_sat = 1'b0;
        cyc();
        press();
        for (int k = 1; k <= 54; k++) begin
            tick();
            if (k == 10) expect_v(SH, 255, "sat_t10");
            if (k == 11) expect_v(SH, 255, "sat_t11_nowrap");
            if (k == 30) expect_v(SH, 255, "sat_t30");
            if (k == 32) expect_v(SH, 254, "sat_t32");
            if (k == 53) begin
                expect_v(SH, 2, "sat_t53");
                expect_v(SA, 1, "sat_air_t53");
            end
            if (k == 54) begin
                expect_v(SH, 0, "sat_land_h");
                expect_v(SA, 0, "sat_land_air");
            end
            if (sb.size() > 0) flush();
        end

        cyc();
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
